btn_event_scheduler: RTL

Collects debounced press/release pulses from `N_BTN` push-button debouncers, adds long-press and auto-repeat detection per button, and serialises every resulting event into one FIFO. Consumers drain the FIFO through a valid/ready handshake. The block sits between the per-button debouncers and the lab's control FSMs and display logic, so those consumers see one ordered event stream instead of N asynchronous pulse pairs.

---
 rtl/btn_evt_pkg.sv | 31 +++
 rtl/btn_event_fifo.sv | 53 +++++
 rtl/btn_event_scheduler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
// Shared event/state types for the button event scheduler.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
package btn_evt_pkg;

   localparam int BTN_W = 8;

   typedef enum logic [1:0] {
      EV_PRESS   = 2'd0,
      EV_RELEASE = 2'd1,
      EV_LONG    = 2'd2,
      EV_REPEAT  = 2'd3
   } ev_type_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_LONG = 2'd2
   } btn_state_t;

   typedef struct packed {
      logic [BTN_W-1:0] btn;
      ev_type_t         typ;
   } btn_event_t;

   localparam int EV_W = $bits(btn_event_t);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_event_fifo.sv
// Synchronous event FIFO; a push is accepted while full if a pop
// happens in the same cycle.
module btn_event_fifo
   import btn_evt_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic [EV_W-1:0] din,
   input  logic            pop,
   output logic [EV_W-1:0] dout,
   output logic            full,
   output logic            empty
);

   localparam int AW = $clog2(DEPTH);

   btn_event_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/btn_event_scheduler.sv
// Per-button press/long/repeat FSMs, round-robin slot arbiter and event FIFO.
// Define BTN_AUTOREPEAT_EN to emit REPEAT events while a button stays in LONG.
module btn_event_scheduler
   import btn_evt_pkg::*;
#(
   parameter int N_BTN         = 4,
   parameter int LONG_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_BTN-1:0]         pb_status,
   input  logic [N_BTN-1:0]         pb_pressed_pulse,
   input  logic [N_BTN-1:0]         pb_released_pulse,
   output logic                     ev_valid,
   input  logic                     ev_ready,
   output logic [$clog2(N_BTN)-1:0] ev_btn,
   output logic [1:0]               ev_type,
   output logic                     ovf,
   input  logic                     ovf_clr
);

   localparam int IW = $clog2(N_BTN);
   localparam int TW = $clog2(max2(LONG_CYCLES, REPEAT_CYCLES));

   logic [N_BTN-1:0] grant;
   logic [N_BTN-1:0] slot_v;
   logic [N_BTN-1:0] drop;
   ev_type_t         slot_t [N_BTN];

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_state_t    state;
      btn_state_t    state_nx;
      logic [TW-1:0] timer;
      logic [TW-1:0] timer_nx;
      logic          hit_long;
      logic          emit;
      ev_type_t      emit_t;
      logic          sv;
      ev_type_t      st;

      assign hit_long = (timer == TW'(LONG_CYCLES - 1));
`ifdef BTN_AUTOREPEAT_EN
      logic hit_rep;
      assign hit_rep = (timer == TW'(REPEAT_CYCLES - 1));
`endif

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state <= ST_IDLE;
            timer <= '0;
         end else begin
            state <= state_nx;
            timer <= timer_nx;
         end
      end

      always_comb begin
         state_nx = state;
         timer_nx = '0;
         if (pb_released_pulse[i]) begin
            state_nx = ST_IDLE;
         end else begin
            unique case (1'b1)
               state == ST_IDLE: begin
                  if (pb_pressed_pulse[i]) state_nx = ST_HELD;
               end
               state == ST_HELD: begin
                  if (!pb_status[i])  state_nx = ST_IDLE;
                  else if (hit_long)  state_nx = ST_LONG;
                  else                timer_nx = timer + 1'b1;
               end
               state == ST_LONG: begin
                  if (!pb_status[i]) state_nx = ST_IDLE;
`ifdef BTN_AUTOREPEAT_EN
                  else if (!hit_rep) timer_nx = timer + 1'b1;
`endif
               end
               default: state_nx = ST_IDLE;
            endcase
         end
      end

      always_comb begin
         emit   = 1'b0;
         emit_t = EV_PRESS;
         if (pb_released_pulse[i]) begin
            emit   = 1'b1;
            emit_t = EV_RELEASE;
         end else begin
            unique case (1'b1)
               state == ST_IDLE && pb_pressed_pulse[i]: begin
                  emit   = 1'b1;
                  emit_t = EV_PRESS;
               end
               state == ST_HELD && pb_status[i] && hit_long: begin
                  emit   = 1'b1;
                  emit_t = EV_LONG;
               end
`ifdef BTN_AUTOREPEAT_EN
               state == ST_LONG && pb_status[i] && hit_rep: begin
                  emit   = 1'b1;
                  emit_t = EV_REPEAT;
               end
`endif
               default: ;
            endcase
         end
      end

      // A full slot only takes a new event if it is being drained this cycle.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            sv <= 1'b0;
            st <= EV_PRESS;
         end else if (emit) begin
            if (!sv || grant[i]) begin
               sv <= 1'b1;
               st <= emit_t;
            end
         end else if (grant[i]) begin
            sv <= 1'b0;
         end
      end

      assign slot_v[i] = sv;
      assign slot_t[i] = st;
      assign drop[i]   = emit && sv && !grant[i];
   end

   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic          can_push;
   logic          gnt_any;
   logic [IW-1:0] gnt_idx;
   logic [IW-1:0] rr_ptr;
   btn_event_t    ev_in;
   btn_event_t    head;
   logic          unused_btn;

   assign ev_valid = !fifo_empty;
   assign pop      = ev_valid && ev_ready;
   assign can_push = !fifo_full || pop;

   always_comb begin
      int j;
      j       = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      grant   = '0;
      for (int k = 0; k < N_BTN; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= N_BTN) j = j - N_BTN;
         if (!gnt_any && can_push && slot_v[j]) begin
            gnt_any  = 1'b1;
            gnt_idx  = IW'(j);
            grant[j] = 1'b1;
         end
      end
   end

   always_comb begin
      ev_in     = '0;
      ev_in.btn = BTN_W'(gnt_idx);
      ev_in.typ = slot_t[gnt_idx];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         if (gnt_any)
            rr_ptr <= (gnt_idx == IW'(N_BTN - 1)) ? '0 : gnt_idx + 1'b1;
         if (|drop)        ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

   btn_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (gnt_any),
      .din   (ev_in),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign ev_btn     = head.btn[IW-1:0];
   assign ev_type    = head.typ;
   assign unused_btn = ^head.btn;

endmodule
